// File: rtl/gift_effect.sv
// gift_effect: detects when a falling gift lands on the paddle and applies
// the gift's effect to the paddle width, ball speed, timed effect flags and
// the extra-ball request.
//
// Ports:
//   clock, reset        system clock; synchronous active-high reset
//   enable              frame tick; hit checks and effect timers advance on it
//   gift_active         a gift is currently falling
//   gift_kind           0 INC,1 DEC,2 SPU,3 SPD,4 HID,5 SOT,6 DRP,7 MUL
//   gift_x, gift_y      gift top-left position
//   paddle_x            paddle left edge
//   gift_clear          one-cycle pulse: deactivate the caught gift
//   width_lvl, paddle_w paddle width level and decoded width (32*(lvl+1))
//   speed_lvl           ball speed level
//   hidden, shoot_en, drop_en  timed effect flags
//   multi_req           one-cycle pulse requesting extra balls
module gift_effect #(
    parameter logic [9:0]  PADDLE_Y     = 10'd440,
    parameter logic [9:0]  PADDLE_H     = 10'd8,
    parameter logic [9:0]  GIFT_W       = 10'd16,
    parameter logic [9:0]  GIFT_H       = 10'd8,
    parameter logic [11:0] EFFECT_TICKS = 12'd600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       gift_active,
    input  logic [2:0] gift_kind,
    input  logic [9:0] gift_x,
    input  logic [9:0] gift_y,
    input  logic [9:0] paddle_x,
    output logic       gift_clear,
    output logic [1:0] width_lvl,
    output logic [9:0] paddle_w,
    output logic [1:0] speed_lvl,
    output logic       hidden,
    output logic       shoot_en,
    output logic       drop_en,
    output logic       multi_req
);
    typedef enum logic [1:0] {IDLE, TRACK, APPLY, WAIT_CLR} state_t;

    localparam logic [2:0] K_INC = 3'd0, K_DEC = 3'd1, K_SPU = 3'd2, K_SPD = 3'd3,
                           K_HID = 3'd4, K_SOT = 3'd5, K_DRP = 3'd6, K_MUL = 3'd7;

    state_t      state;
    logic [11:0] timer [3];   // 0 HID, 1 SOT, 2 DRP
    logic [2:0]  flag;

    // Overlap test in 11 bits so right/bottom edges near 1023 cannot wrap.
    logic [10:0] gx_end, gy_end, px_end, py_end;
    logic        hit, catch_now;
    logic [1:0]  width_nxt, speed_nxt;
    logic [2:0]  width_inc;

    assign gx_end = {1'b0, gift_x} + {1'b0, GIFT_W};
    assign gy_end = {1'b0, gift_y} + {1'b0, GIFT_H};
    assign px_end = {1'b0, paddle_x} + {1'b0, paddle_w};
    assign py_end = {1'b0, PADDLE_Y} + {1'b0, PADDLE_H};

    assign hit = ({1'b0, gift_x} < px_end) && (gx_end > {1'b0, paddle_x}) &&
                 (gy_end >= {1'b0, PADDLE_Y}) && ({1'b0, gift_y} < py_end);

    // The catch commits the gift's effect on the detecting edge, so the new
    // levels and pulses are visible throughout the single APPLY cycle; the
    // kind is captured directly into the effect registers at that edge.
    assign catch_now = (state == TRACK) && gift_active && enable && hit;

    always_comb begin
        width_nxt = width_lvl;
        speed_nxt = speed_lvl;
        if (catch_now) begin
            case (gift_kind)
                K_INC: if (width_lvl != 2'd3) width_nxt = width_lvl + 2'd1;
                K_DEC: if (width_lvl != 2'd0) width_nxt = width_lvl - 2'd1;
                K_SPU: if (speed_lvl != 2'd3) speed_nxt = speed_lvl + 2'd1;
                K_SPD: if (speed_lvl != 2'd0) speed_nxt = speed_lvl - 2'd1;
                default: ;
            endcase
        end
    end

    assign width_inc = {1'b0, width_nxt} + 3'd1;

    assign hidden   = flag[0];
    assign shoot_en = flag[1];
    assign drop_en  = flag[2];

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            width_lvl  <= 2'd1;
            paddle_w   <= 10'd64;
            speed_lvl  <= 2'd1;
            flag       <= 3'b000;
            gift_clear <= 1'b0;
            multi_req  <= 1'b0;
            for (int i = 0; i < 3; i++) timer[i] <= 12'd0;
        end else begin
            gift_clear <= 1'b0;
            multi_req  <= 1'b0;
            width_lvl  <= width_nxt;
            speed_lvl  <= speed_nxt;
            paddle_w   <= {2'b00, width_inc, 5'b00000};

            // Flag drops on the same edge its timer reaches zero.
            for (int i = 0; i < 3; i++) begin
                if (enable && timer[i] != 12'd0) begin
                    timer[i] <= timer[i] - 12'd1;
                    if (timer[i] == 12'd1) flag[i] <= 1'b0;
                end
            end

            case (state)
                IDLE:     if (gift_active) state <= TRACK;
                TRACK: begin
                    if (!gift_active) state <= IDLE;
                    else if (catch_now) begin
                        state      <= APPLY;
                        gift_clear <= 1'b1;
                        multi_req  <= (gift_kind == K_MUL);
                        // Reload is written after the decrement so it wins.
                        if (gift_kind == K_HID || gift_kind == K_SOT || gift_kind == K_DRP) begin
                            timer[gift_kind[1:0]] <= EFFECT_TICKS;
                            flag[gift_kind[1:0]]  <= 1'b1;
                        end
                    end
                end
                APPLY:    state <= WAIT_CLR;
                WAIT_CLR: if (!gift_active) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gift_effect.sv
module tb_gift_effect;
    logic       clock = 1'b0;
    logic       reset, enable, gift_active;
    logic [2:0] gift_kind;
    logic [9:0] gift_x, gift_y, paddle_x;
    logic       gift_clear, hidden, shoot_en, drop_en, multi_req;
    logic [1:0] width_lvl, speed_lvl;
    logic [9:0] paddle_w;

    int n_chk  = 0;
    int n_fail = 0;

    gift_effect #(.EFFECT_TICKS(12'd4)) dut (
        .clock(clock), .reset(reset), .enable(enable), .gift_active(gift_active),
        .gift_kind(gift_kind), .gift_x(gift_x), .gift_y(gift_y), .paddle_x(paddle_x),
        .gift_clear(gift_clear), .width_lvl(width_lvl), .paddle_w(paddle_w),
        .speed_lvl(speed_lvl), .hidden(hidden), .shoot_en(shoot_en),
        .drop_en(drop_en), .multi_req(multi_req)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] kind;
        logic [9:0] x, y, px;
        logic       clr;
        logic [1:0] w;
        logic [9:0] pw;
        logic [1:0] spd;
        logic       mul;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_clear"}, gift_clear, 0);
        chk({tag, "_width"}, width_lvl, 1);
        chk({tag, "_pw"}, paddle_w, 64);
        chk({tag, "_speed"}, speed_lvl, 1);
        chk({tag, "_flags"}, {hidden, shoot_en, drop_en}, 0);
        chk({tag, "_multi"}, multi_req, 0);
    endtask

    // Ends at the negedge after the enable edge (APPLY if the gift was caught).
    task automatic catch_try(input logic [2:0] k, input logic [9:0] x, y, px);
        @(negedge clock);
        gift_active = 1'b1; gift_kind = k; gift_x = x; gift_y = y; paddle_x = px;
        enable = 1'b0;
        @(negedge clock);
        enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
    endtask

    task automatic release_gift();
        gift_active = 1'b0;
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic tick();
        enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
    endtask

    initial begin
        int n_clr, n_mul;
        //         kind  x     y    px    clr  w  pw   spd mul
        tbl[0]  = '{3'd0, 100, 435,  90, 1, 2,  96, 1, 0};  // basic INC
        tbl[1]  = '{3'd0, 100, 435,  90, 1, 3, 128, 1, 0};
        tbl[2]  = '{3'd0, 100, 435,  90, 1, 3, 128, 1, 0};  // saturate high
        tbl[3]  = '{3'd1, 100, 435,  90, 1, 2,  96, 1, 0};
        tbl[4]  = '{3'd2, 100, 440,  90, 1, 2,  96, 2, 0};
        tbl[5]  = '{3'd2, 100, 440,  90, 1, 2,  96, 3, 0};
        tbl[6]  = '{3'd2, 100, 440,  90, 1, 2,  96, 3, 0};  // speed saturates
        tbl[7]  = '{3'd3, 100, 440,  90, 1, 2,  96, 2, 0};
        tbl[8]  = '{3'd0, 300, 440,  90, 0, 2,  96, 2, 0};  // far right: miss
        tbl[9]  = '{3'd7, 100, 440,  90, 1, 2,  96, 2, 1};  // MUL
        tbl[10] = '{3'd1, 100, 432,  90, 1, 1,  64, 2, 0};  // bottom edge touches top
        tbl[11] = '{3'd1, 100, 448,  90, 0, 1,  64, 2, 0};  // below paddle: miss
        tbl[12] = '{3'd0, 154, 440,  90, 0, 1,  64, 2, 0};  // x == right edge: miss
        tbl[13] = '{3'd0,  75, 440,  90, 1, 2,  96, 2, 0};  // 1-pixel left overlap
        tbl[14] = '{3'd0,1010, 440,1000, 1, 3, 128, 2, 0};  // no wrap near 1023

        reset = 1'b1; enable = 1'b0; gift_active = 1'b0;
        gift_kind = 3'd0; gift_x = 10'd0; gift_y = 10'd0; paddle_x = 10'd0;
        repeat (2) @(negedge clock);
        chk_reset_vals("reset");
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            catch_try(tbl[i].kind, tbl[i].x, tbl[i].y, tbl[i].px);
            chk($sformatf("v%0d_clear", i), gift_clear, tbl[i].clr);
            chk($sformatf("v%0d_width", i), width_lvl, tbl[i].w);
            chk($sformatf("v%0d_pw", i), paddle_w, tbl[i].pw);
            chk($sformatf("v%0d_speed", i), speed_lvl, tbl[i].spd);
            chk($sformatf("v%0d_multi", i), multi_req, tbl[i].mul);
            release_gift();
            chk($sformatf("v%0d_clear_done", i), gift_clear, 0);
        end

        // HID lifetime with reload at tick 2
        catch_try(3'd4, 100, 440, 90);
        chk("hid_set", hidden, 1);
        release_gift();
        for (int t = 1; t <= 2; t++) begin
            tick();
            chk($sformatf("hid_t%0d", t), hidden, 1);
        end
        catch_try(3'd4, 100, 440, 90);
        chk("hid_reload", hidden, 1);
        release_gift();
        for (int t = 1; t <= 4; t++) begin
            tick();
            chk($sformatf("hid_r%0d", t), hidden, (t < 4) ? 1 : 0);
        end
        tick();
        chk("hid_stays_off", hidden, 0);

        // MUL with gift held and enable high: a single catch only
        @(negedge clock);
        gift_active = 1'b1; gift_kind = 3'd7; gift_x = 10'd100; gift_y = 10'd440;
        paddle_x = 10'd90; enable = 1'b1;
        n_clr = 0; n_mul = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            n_clr += int'(gift_clear);
            n_mul += int'(multi_req);
        end
        enable = 1'b0;
        chk("mul_clear_count", n_clr, 1);
        chk("mul_pulse_count", n_mul, 1);
        release_gift();

        // Reset while in WAIT_CLR with timed effects running
        catch_try(3'd6, 100, 440, 90);
        chk("drp_set", drop_en, 1);
        release_gift();
        catch_try(3'd5, 100, 440, 90);
        chk("sot_set", shoot_en, 1);
        @(negedge clock);
        chk("sot_hold", shoot_en, 1);
        reset = 1'b1;
        @(negedge clock);
        chk_reset_vals("midreset");
        reset = 1'b0;
        gift_active = 1'b0;
        repeat (2) @(negedge clock);
        chk("after_reset_clear", gift_clear, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
